// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB slave register block.
package apb_slv_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam logic [31:0] APB_SLV_ID_DEFAULT = 32'hA0B1_0001;

  // The wait counter must hold WAIT_CYCLES, but is never narrower than one bit.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB bus bundle between a bridge (master) and the register slave.
interface apb_slave_regs_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                  PSEL;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_slv_regfile.sv
// Word register array with one write port and a read mux; entry 0 is a constant ID.
module apb_slv_regfile
  import apb_slv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(APB_SLV_ID_DEFAULT),
  localparam int                   IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Slot 0 is never written; it reads back as ID_VALUE.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (addr_i != '0)) begin
      regs_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = (addr_i == '0) ? ID_VALUE : regs_q[addr_i];

endmodule

// File: rtl/apb_slave_regs.sv
// APB slave with NUM_REGS word registers and WAIT_CYCLES wait states per access.
// Optional macro APB_SLV_PSLVERR_EN enables PSLVERR on bad address / register-0 writes.
module apb_slave_regs
  import apb_slv_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(APB_SLV_ID_DEFAULT)
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_slave_regs_if.slave apb
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int HI_LSB = IDX_W + 2;
  localparam int CNT_W  = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  apb_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  pready_q;
  logic                  wr_q;
  logic                  oor_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [ADDR_WIDTH-1:0] paddr_hi;
  logic                  oor_d;
  logic                  setup;
  logic                  complete;
  logic                  we;
  logic [DATA_WIDTH-1:0] rdata;

  // Any address bit above the word index, or a non word-aligned byte offset, is out of range.
  assign paddr_hi = apb.PADDR >> HI_LSB;
  assign oor_d    = (|paddr_hi) || (|apb.PADDR[1:0]);
  assign setup    = (state_q == IDLE) && apb.PSEL && !apb.PENABLE;
  assign complete = (state_q == ACCESS) && apb.PSEL && apb.PENABLE && pready_q;
  assign we       = complete && wr_q && !oor_q;

  // PREADY is kept as a register that rises exactly when the counter reaches zero.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pready_q <= 1'b0;
      wr_q     <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pready_q <= 1'b0;
          if (setup) begin
            state_q  <= ACCESS;
            cnt_q    <= WAIT_LD;
            pready_q <= (WAIT_CYCLES == 0);
            wr_q     <= apb.PWRITE;
            oor_q    <= oor_d;
          end
        end
        ACCESS: begin
          if (!apb.PSEL) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pready_q <= 1'b0;
          end else if (complete) begin
            state_q  <= IDLE;
            pready_q <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q    <= cnt_q - 1'b1;
            pready_q <= (cnt_q == CNT_W'(1));
          end
        end
        default: begin
          state_q  <= IDLE;
          pready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (setup) begin
      idx_q   <= apb.PADDR[IDX_W+1:2];
      wdata_q <= apb.PWDATA;
    end
  end

  apb_slv_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE)
  ) u_regfile (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .we_i    (we),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

  assign apb.PREADY = pready_q;
  assign apb.PRDATA = (pready_q && !wr_q && !oor_q) ? rdata : '0;

`ifdef APB_SLV_PSLVERR_EN
  assign apb.PSLVERR = pready_q && (oor_q || (wr_q && (idx_q == '0)));
`else
  assign apb.PSLVERR = 1'b0;
`endif

endmodule

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register and data width.
REQ-003 SHALL have parameter NUM_REGS, default 16, number of word registers (power of two, >=2).
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, access-phase wait states before PREADY (0..15).
REQ-005 SHALL have parameter ID_VALUE, default 32'hA0B1_0001, constant read-only content of register 0.
REQ-006 SHALL have port PCLK input 1 -- single clock; all state on rising edge.
REQ-007 SHALL have port PRESET input 1 -- reset, asynchronous and active-high.
REQ-008 SHALL have port PSEL input 1 -- slave select from the bridge.
REQ-009 SHALL have port PENABLE input 1 -- access-phase indicator.
REQ-010 SHALL have port PADDR input ADDR_WIDTH -- byte address; word index = PADDR[$clog2(NUM_REGS)+1:2].
REQ-011 SHALL have port PWRITE input 1 -- 1 write, 0 read.
REQ-012 SHALL have port PWDATA input DATA_WIDTH -- write data.
REQ-013 SHALL have port PRDATA output DATA_WIDTH -- read data, valid only while PREADY high on a read.
REQ-014 SHALL have port PREADY output 1 -- transfer completes at edge where PSEL&PENABLE&PREADY.
REQ-015 SHALL have port PSLVERR output 1 -- error response, valid only with PREADY.

Function
REQ-016 SHALL implement FSM with states IDLE and ACCESS.
REQ-017 IDLE: on edge with PSEL&!PENABLE, latch address index, PWRITE, PWDATA, out-of-range flag; load wait counter = WAIT_CYCLES; go to ACCESS.
REQ-018 ACCESS: counter decrements by 1 each cycle while nonzero; PREADY = (state==ACCESS)&&(counter==0), so PREADY first high WAIT_CYCLES+1 cycles after the setup edge.
REQ-019 Completion edge (ACCESS, PSEL&PENABLE&PREADY): write commits latched data to register (if writable and no error); FSM returns to IDLE.
REQ-020 Back-to-back: setup phase in the cycle after completion SHALL be accepted with no added idle cycle.
REQ-021 Abort: PSEL low in ACCESS before completion SHALL return FSM to IDLE, no register update, PREADY low next cycle.
REQ-022 PRDATA = selected register when PREADY high and latched PWRITE=0; otherwise all zeros.
REQ-023 Register 0 SHALL always read ID_VALUE; writes to it are discarded.
REQ-024 Address out of range (PADDR bits above word index nonzero, or PADDR[1:0]!=0): read returns zero, write discarded.
REQ-025 PREADY, PRDATA, PSLVERR SHALL be low whenever state is IDLE.
REQ-026 Counter width SHALL be $clog2(WAIT_CYCLES+1), minimum 1; WAIT_CYCLES=0 gives PREADY in first access cycle.

Reset
REQ-027 PRESET high SHALL immediately force IDLE, counter 0, registers 1..NUM_REGS-1 to 0, PREADY/PSLVERR/PRDATA to 0.
REQ-028 Reset mid-transfer SHALL drop the transfer with no register update.

Configuration
REQ-029 With APB_SLV_PSLVERR_EN defined, PSLVERR = PREADY && (out-of-range OR write to register 0); otherwise PSLVERR is tied 0 and such accesses complete silently per REQ-023/REQ-024.

Structure
REQ-030 Package apb_slv_pkg SHALL hold the FSM state enum (IDLE, ACCESS) and the default ID_VALUE constant.
REQ-031 Sub-module apb_slv_regfile SHALL hold the register array, write port, and read mux; FSM and counter stay in apb_slave_regs.

Verification
REQ-032 Write 32'hDEAD_BEEF to 0x08, read 0x08 -> PREADY high 3 cycles after each setup edge, PRDATA=32'hDEAD_BEEF, PSLVERR=0.
REQ-033 Read 0x00 after write of 32'h1234_5678 to 0x00 -> PRDATA=ID_VALUE; PSLVERR=1 on the write only with APB_SLV_PSLVERR_EN.
REQ-034 Read 0x40 (NUM_REGS=16) -> PRDATA=0, PSLVERR=1 with macro, 0 without.
REQ-035 Two back-to-back writes 0x04=1, 0x0C=2 then reads -> no idle cycle between transfers, values 1 and 2 returned.
REQ-036 Write 0x10 with PSEL dropped during wait, then read 0x10 -> returns 0; PRESET pulse during ACCESS of write to 0x14 -> PREADY low immediately, 0x14 reads 0.
REQ-037 WAIT_CYCLES=0 build: write/read 0x04 -> PREADY high in the first access cycle.
